// File: rtl/compressor_result_serializer.sv
// rtl/compressor_result_serializer.sv - latches the two-row compressor result and shifts it out bit-serially
module compressor_result_serializer #(
    parameter int NCOL  = 9,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [NCOL-1:0] row0,
    input  logic [NCOL-1:0] row1,
    output logic            ready,
    output logic            sout,
    output logic            sout_valid,
    output logic            last,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NCOL_C   = CNT_W'(NCOL);
    localparam logic [CNT_W-1:0] RAW_LAST = CNT_W'(2 * NCOL - 1);

    state_t           state, state_nxt;
    logic [NCOL-1:0]  a_q, b_q;
    logic             mode_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic             in_rows;
    logic             final_bit;

    // SUM frames end on the carry bit at count==NCOL; RAW frames after both rows.
    assign in_rows   = (count_q < NCOL_C);
    assign final_bit = mode_q ? (count_q == RAW_LAST) : (count_q == NCOL_C);

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                sout_valid = 1'b1;
                last       = final_bit;
                if (mode_q) sout = in_rows ? a_q[0] : b_q[0];
                else        sout = in_rows ? (a_q[0] ^ b_q[0] ^ carry_q) : carry_q;
                if (final_bit) state_nxt = DONE_ST;
            end
            DONE_ST: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= row0;
                        b_q     <= row1;
                        mode_q  <= mode;
                        carry_q <= 1'b0;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    count_q <= count_q + 1'b1;
                    if (mode_q) begin
                        if (in_rows) a_q <= a_q >> 1;
                        else         b_q <= b_q >> 1;
                    end else if (in_rows) begin
                        carry_q <= (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
                        a_q     <= a_q >> 1;
                        b_q     <= b_q >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compressor_result_serializer.sv
// tb/tb_compressor_result_serializer.sv - scoreboard bench for compressor_result_serializer
module tb_compressor_result_serializer;

    localparam int NCOL = 9;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            mode;
    logic [NCOL-1:0] row0;
    logic [NCOL-1:0] row1;
    logic            ready;
    logic            sout;
    logic            sout_valid;
    logic            last;
    logic            done;

    compressor_result_serializer #(.NCOL(NCOL), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .row0       (row0),
        .row1       (row1),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Each entry is {last, bit}.
    logic [1:0] exp_q[$];

    logic last_prev  = 1'b0;
    logic gap_check  = 1'b0;
    logic gap_active = 1'b0;
    int   gap_n      = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [17:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), v[i]});
    endtask

    task automatic push_frame(input logic m, input logic [NCOL-1:0] r0, input logic [NCOL-1:0] r1);
        logic [NCOL:0] s;
        if (m == 1'b0) begin
            s = {1'b0, r0} + {1'b0, r1};
            push_bits(18'(s), NCOL + 1);
        end else begin
            push_bits({r1, r0}, 2 * NCOL);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic launch(input logic m, input logic [NCOL-1:0] r0, input logic [NCOL-1:0] r1);
        wait_ready();
        mode  = m;
        row0  = r0;
        row1  = r1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (sout_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sout", sout, e[0]);
                chk("last", last, e[1]);
            end
            if (gap_check && gap_active) chk("frame_gap", gap_n, 2);
            gap_active = 1'b0;
            if (last) begin
                gap_active = 1'b1;
                gap_n      = 0;
            end
        end else begin
            if (last) chk("last_without_valid", 1, 0);
            if (gap_active) gap_n++;
        end
        if (done || last_prev) chk("done_after_last", done, last_prev);
        if (done) done_cnt++;
        last_prev = sout_valid & last;
    end

    initial begin
        int d0;
        logic m;
        logic [NCOL-1:0] r0, r1;

        rst_n = 1'b0;
        start = 1'b1;
        mode  = 1'b0;
        row0  = '0;
        row1  = '0;

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ready", ready, 1);
            chk("rst_valid", sout_valid, 0);
            chk("rst_done", done, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", ready, 1);

        // SUM carry ripple: 1FF + 001 = 200
        d0 = done_cnt;
        push_bits(18'h00200, 10);
        launch(1'b0, 9'h1FF, 9'h001);
        drain();
        chk("t2_done_count", done_cnt - d0, 1);

        // RAW: {13C, 0A5}
        d0 = done_cnt;
        push_bits(18'h278A5, 18);
        launch(1'b1, 9'h0A5, 9'h13C);
        drain();
        chk("t3_done_count", done_cnt - d0, 1);

        // Busy start ignored: 0F0 + 0FF = 1EF
        d0 = done_cnt;
        push_bits(18'h001EF, 10);
        launch(1'b0, 9'h0F0, 9'h0FF);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 1'b1;
        row0  = 9'h1FF;
        row1  = 9'h1FF;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        chk("t4_done_count", done_cnt - d0, 1);

        // Mid-frame reset on bit 4 of a SUM frame (155 + 0AA = 1FF)
        push_bits(18'h001FF, 10);
        launch(1'b0, 9'h155, 9'h0AA);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        chk("t5_valid_after_rst", sout_valid, 0);
        chk("t5_ready_after_rst", ready, 1);
        d0 = done_cnt;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        push_bits(18'h00200, 10);
        launch(1'b0, 9'h0FF, 9'h101);
        drain();
        chk("t5_done_count", done_cnt - d0, 1);

        // Random back-to-back frames with start held high
        d0         = done_cnt;
        gap_active = 1'b0;
        gap_check  = 1'b1;
        start      = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            wait_ready();
            m  = 1'($urandom_range(0, 1));
            r0 = NCOL'($urandom);
            r1 = NCOL'($urandom);
            mode = m;
            row0 = r0;
            row1 = r1;
            push_frame(m, r0, r1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        drain();
        gap_check = 1'b0;
        chk("t6_done_count", done_cnt - d0, 1000);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
